// File: rtl/alu_checker_if.sv
// Stimulus/result bus between the ALU stimulus side and the alu_checker monitor.
// The sampled tuple is opcode/a/b/dut_out plus the checker's statistics and first-failure capture.
interface alu_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  // Handshake: valid has no ready. A tuple is taken on every rising edge where valid=1,
  // unless the checker has already accepted its programmed count or is being reset/cleared.
  logic             valid;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] dut_out;

  logic             cmp_valid;
  logic             cmp_match;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err;
  logic [2:0]       ff_opcode;
  logic [WIDTH-1:0] ff_a;
  logic [WIDTH-1:0] ff_b;
  logic [WIDTH-1:0] ff_out;
  logic [WIDTH-1:0] ff_exp;
  logic             done;

  modport master (
    output valid, opcode, a, b, dut_out,
    input  cmp_valid, cmp_match, pass_cnt, fail_cnt, err,
    input  ff_opcode, ff_a, ff_b, ff_out, ff_exp, done
  );

  modport slave (
    input  valid, opcode, a, b, dut_out,
    output cmp_valid, cmp_match, pass_cnt, fail_cnt, err,
    output ff_opcode, ff_a, ff_b, ff_out, ff_exp, done
  );
endinterface

// File: rtl/alu_checker.sv
// Two-stage ALU result checker: stage 1 latches the tuple and golden value, stage 2 compares,
// keeps saturating pass/fail counts and captures the first mismatching tuple.
module alu_checker #(
  parameter int WIDTH    = 8,
  parameter int N_CHECKS = 6,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic [1:0]        dbg_state,
  alu_checker_if.slave      bus
);
  localparam int ACC_W = $clog2(N_CHECKS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_cnt;
  logic             accept;
  logic [WIDTH-1:0] golden;
  logic             match;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_out;
  logic [WIDTH-1:0] s1_exp;

  assign dbg_state = state;
  assign accept    = bus.valid && (state != DONE) && (acc_cnt < ACC_W'(N_CHECKS));
  // Case equality so an X/Z on the checked result is reported as a mismatch.
  assign match     = (s1_out === s1_exp);

  always_comb begin
    golden = '0;
    case (bus.opcode)
      3'd0:    golden = bus.a + bus.b;
      3'd1:    golden = bus.a - bus.b;
      3'd2:    golden = bus.a & bus.b;
      3'd3:    golden = bus.a | bus.b;
      3'd4:    golden = bus.a ^ bus.b;
      3'd5:    golden = ~bus.a;
      3'd6:    golden = bus.a << 1;
      default: golden = bus.a >> 1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state         <= IDLE;
      acc_cnt       <= '0;
      s1_valid      <= 1'b0;
      s1_op         <= '0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_out        <= '0;
      s1_exp        <= '0;
      bus.cmp_valid <= 1'b0;
      bus.cmp_match <= 1'b0;
      bus.pass_cnt  <= '0;
      bus.fail_cnt  <= '0;
      bus.err       <= 1'b0;
      bus.ff_opcode <= '0;
      bus.ff_a      <= '0;
      bus.ff_b      <= '0;
      bus.ff_out    <= '0;
      bus.ff_exp    <= '0;
      bus.done      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op   <= bus.opcode;
        s1_a    <= bus.a;
        s1_b    <= bus.b;
        s1_out  <= bus.dut_out;
        s1_exp  <= golden;
        acc_cnt <= acc_cnt + ACC_W'(1);
      end

      bus.cmp_valid <= s1_valid;
      bus.cmp_match <= s1_valid && match;
      if (s1_valid) begin
        if (match) begin
          if (bus.pass_cnt != '1) bus.pass_cnt <= bus.pass_cnt + CNT_W'(1);
        end else begin
          if (bus.fail_cnt != '1) bus.fail_cnt <= bus.fail_cnt + CNT_W'(1);
          if (!bus.err) begin
            bus.err       <= 1'b1;
            bus.ff_opcode <= s1_op;
            bus.ff_a      <= s1_a;
            bus.ff_b      <= s1_b;
            bus.ff_out    <= s1_out;
            bus.ff_exp    <= s1_exp;
          end
        end
      end

      case (state)
        IDLE: if (accept) state <= RUN;
        // The last accepted tuple finishes in stage 2 on this edge, so done lines up with its cmp_valid.
        RUN: begin
          if (s1_valid && (acc_cnt == ACC_W'(N_CHECKS))) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_checker.md
Name: alu_checker

Overview:
- Synthesizable self-checking monitor at the receiving end of the 8-bit ALU stimulus interface (opcode, a, b → out).
- Samples each operand/result tuple on a valid strobe, recomputes the golden result, compares it with the DUT output, and keeps pass/fail statistics plus a first-failure capture.
- Sits beside the alu instance in simulation and on-board bring-up; stops after a programmed check count.

Parameters:
- WIDTH, 8, operand/result width.
- N_CHECKS, 6, number of compared tuples before entering DONE (matches 1 initial + 5 repeated vectors).
- CNT_W, 16, width of pass/fail counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- clear  input  1  synchronous restart: counters, capture and FSM return to IDLE (same effect as rst).
- valid  input  1  tuple on opcode/a/b/dut_out is sampled this cycle.
- opcode  input  3  ALU operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- dut_out  input  WIDTH  ALU result under check.
- cmp_valid  output  1  one-cycle pulse: a comparison completed.
- cmp_match  output  1  result of that comparison (meaningful only when cmp_valid=1).
- pass_cnt  output  CNT_W  saturating count of matches.
- fail_cnt  output  CNT_W  saturating count of mismatches.
- err  output  1  sticky; set on the first mismatch.
- ff_opcode / ff_a / ff_b / ff_out  output  3/WIDTH/WIDTH/WIDTH  tuple of the first mismatch.
- ff_exp  output  WIDTH  expected value for the first mismatch.
- done  output  1  high in DONE state.

Behaviour:
- Golden opcode map (mod 2^WIDTH, carry dropped):
  - 0 a+b
  - 1 a−b
  - 2 a&b
  - 3 a|b
  - 4 a^b
  - 5 ~a
  - 6 a<<1 (zero-fill)
  - 7 a>>1 (logical)
- Reset/clear: all outputs 0; FSM IDLE; internal check counter 0.
- FSM:
  - IDLE → RUN on the first valid; that tuple is accepted.
  - RUN → DONE when the accepted count reaches N_CHECKS.
  - DONE holds until rst/clear. Valid in DONE is ignored: no counter change, no cmp_valid.
- Pipeline:
  - Edge E0 (valid=1, accepted): stage 1 registers opcode, a, b, dut_out and the golden expected value.
  - Edge E1: stage 2 compares. cmp_valid=1 and cmp_match=(dut_out==exp) are visible after E1 for one cycle; pass_cnt or fail_cnt is updated at E1.
  - Latency from valid to counters is 1 clock. Back-to-back valid every cycle is supported (throughput 1).
- done asserts at the edge where the N_CHECKS-th comparison completes, i.e. in the same cycle as the last cmp_valid.
- Acceptance: the accepted-tuple counter increments on accept. Tuples beyond N_CHECKS are never accepted, even if valid is held high.
- Counters saturate at 2^CNT_W−1; no wrap.
- First-failure capture: ff_* and err are loaded only when err=0 and a mismatch completes. Later mismatches do not overwrite them.
- Simultaneous events:
  - rst or clear in the same cycle as valid: reset wins and the tuple is dropped.
  - A tuple in flight in stage 1 is discarded by rst/clear; no cmp_valid follows.
- X/Z on dut_out counts as mismatch (use case equality in the comparison).

Test Plan:
- Happy path, N_CHECKS=6:
  - Drive (op0,a=8'h12,b=8'h34,out=8'h46), (op1,a=8'h10,b=8'h20,out=8'hF0), (op2,F0,3C,30), (op3,F0,0F,FF), (op4,AA,FF,55), (op5,0F,xx,F0).
  - Expect pass_cnt=6, fail_cnt=0, err=0, done=1 after the 6th cmp_valid.
- Shift/wrap edges:
  - op6 a=8'h81 expects 8'h02; op7 a=8'h81 expects 8'h40; op0 FF+01 expects 00.
  - All pass.
- Injected failures:
  - Tuple 2 has out=8'h00 for op0 a=01 b=01; tuple 4 also wrong.
  - Expect fail_cnt=2, err=1, ff_opcode=0, ff_a=01, ff_b=01, ff_out=00, ff_exp=02. Capture is not overwritten by tuple 4.
- Overrun:
  - Hold valid high for 10 cycles with N_CHECKS=6.
  - Expect exactly 6 cmp_valid pulses; pass_cnt+fail_cnt=6; done stays 1.
- Reset mid-operation:
  - Assert rst the cycle after the 3rd valid.
  - Expect no 3rd cmp_valid, all outputs 0, and a fresh run afterwards counting from 0.
- Clear from DONE:
  - Pulse clear.
  - done drops next cycle; a new valid is accepted; err is cleared.
